// File: rtl/simplez_mem_arbiter_pkg.sv
// Shared widths, FSM encoding, port ids and command payload for the Simplez
// main-memory arbiter.
package simplez_mem_pkg;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 12;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/simplez_mem_arbiter_if.sv
// Requester, read-return and memory-side signals of the Simplez memory arbiter.
interface simplez_mem_arbiter_if;
  import simplez_mem_pkg::*;

  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_dout;
  logic          busy;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_dout,
    output p0_ack, p1_ack, rdata,
    output mem_addr, mem_din, mem_we, mem_re, busy
  );

  // Requesters and memory side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_dout,
    input  p0_ack, p1_ack, rdata,
    input  mem_addr, mem_din, mem_we, mem_re, busy
  );

endinterface

// File: rtl/simplez_mem_arbiter_arb2.sv
// Two-way grant decode: a lone request always wins; ties go round-robin or to port 0.
module simplez_arb2
  import simplez_mem_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_c
);

  always_comb begin
    grant_c = PORT_CPU;
    if (req[1] && !req[0]) begin
      grant_c = PORT_LDR;
    end else if (req[1] && req[0]) begin
      grant_c = (PRIO_MODE != 0) ? PORT_CPU : ~last_grant;
    end
  end

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Shares the Simplez 512x12 memory between CPU and loader: IDLE -> ACCESS -> DONE
// sequencer with registered memory controls and per-port one-cycle ack.
module simplez_mem_arbiter
  import simplez_mem_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  simplez_mem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          grant_c;
  mem_cmd_t      cmd_c;

  simplez_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb2 (
    .req        ({bus.p1_req, bus.p0_req}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  // Command of the port that wins this IDLE cycle
  always_comb begin
    cmd_c.we    = bus.p0_we;
    cmd_c.addr  = bus.p0_addr;
    cmd_c.wdata = bus.p0_wdata;
    if (grant_c == PORT_LDR) begin
      cmd_c.we    = bus.p1_we;
      cmd_c.addr  = bus.p1_addr;
      cmd_c.wdata = bus.p1_wdata;
    end
  end

  // Next state; memory controls are loaded on entry to ACCESS so they are live only there
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    p0_ack_d     = p0_ack_q;
    p1_ack_d     = p1_ack_q;
    mem_we_d     = mem_we_q;
    mem_re_d     = mem_re_q;
    busy_d       = busy_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          state_d    = ACCESS;
          owner_d    = grant_c;
          mem_addr_d = cmd_c.addr;
          mem_din_d  = cmd_c.wdata;
          mem_we_d   = cmd_c.we;
          mem_re_d   = ~cmd_c.we;
          busy_d     = 1'b1;
        end
      end
      ACCESS: begin
        state_d  = DONE;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        if (mem_re_q) begin
          rdata_d = bus.mem_dout;
        end
        p0_ack_d = (owner_q == PORT_CPU);
        p1_ack_d = (owner_q == PORT_LDR);
      end
      DONE: begin
        state_d      = IDLE;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        busy_d       = 1'b0;
        last_grant_d = owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_LDR;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.p0_ack   = p0_ack_q;
  assign bus.p1_ack   = p1_ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Scoreboard bench: round-robin arbiter with a falling-edge memory, plus a fixed-priority
// instance checked for port-0 precedence.
module tb_simplez_mem_arbiter;
  import simplez_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  simplez_mem_arbiter_if bus0 ();
  simplez_mem_arbiter_if bus1 ();

  simplez_mem_arbiter #(.PRIO_MODE(0)) dut0 (.clk(clk), .rst(rst),  .bus(bus0));
  simplez_mem_arbiter #(.PRIO_MODE(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  typedef struct {
    bit            chk;
    logic [DW-1:0] rd;
  } exp_t;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t exp0[$];
  exp_t exp1[$];
  bit   own0[$];
  bit   own1[$];
  logic [DW-1:0] mem0    [512];
  logic [DW-1:0] ref_mem [512];
  bit            model_last;
  logic [DW-1:0] model_rdata;
  int            we_cnt = 0;
  bit            prev_ack0, prev_ack1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: registers read data and commits writes on the falling edge
  always @(negedge clk) begin
    if (bus0.mem_we === 1'b1) begin
      mem0[bus0.mem_addr] <= bus0.mem_din;
      we_cnt <= we_cnt + 1;
    end
    if (bus0.mem_re === 1'b1) bus0.mem_dout <= mem0[bus0.mem_addr];
  end

  // Monitor for the round-robin instance
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst === 1'b0) begin
      if (bus0.mem_we || bus0.mem_re) begin
        check("mem_we_re_overlap", 32'(bus0.mem_we & bus0.mem_re), 0);
        check("mem_enable_busy", 32'(bus0.busy), 1);
      end
      if (bus0.p0_ack || bus0.p1_ack) begin
        check("ack_onehot", 32'(bus0.p0_ack ^ bus0.p1_ack), 1);
        if (own0.size() > 0) check("grant_order", 32'(bus0.p1_ack), 32'(own0.pop_front()));
        model_last = bus0.p1_ack;
      end
      if (bus0.p0_ack) begin
        check("p0_ack_pulse", 32'(prev_ack0), 0);
        if (exp0.size() == 0) check("p0_unexpected_ack", 32'(exp0.size()), 1);
        else begin
          e = exp0.pop_front();
          if (e.chk) check("p0_rdata", 32'(bus0.rdata), 32'(e.rd));
        end
      end
      if (bus0.p1_ack) begin
        check("p1_ack_pulse", 32'(prev_ack1), 0);
        if (exp1.size() == 0) check("p1_unexpected_ack", 32'(exp1.size()), 1);
        else begin
          e = exp1.pop_front();
          if (e.chk) check("p1_rdata", 32'(bus0.rdata), 32'(e.rd));
        end
      end
      prev_ack0 = bus0.p0_ack;
      prev_ack1 = bus0.p1_ack;
    end else begin
      prev_ack0 = 1'b0;
      prev_ack1 = 1'b0;
    end
  end

  // Monitor for the fixed-priority instance
  always @(negedge clk) begin
    if (rst1 === 1'b0 && (bus1.p0_ack || bus1.p1_ack)) begin
      if (own1.size() == 0) check("prio_unexpected_ack", 32'(own1.size()), 1);
      else check("prio_grant", 32'(bus1.p1_ack), 32'(own1.pop_front()));
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 1'b0) begin
      bus0.p0_req = req; bus0.p0_we = we; bus0.p0_addr = a; bus0.p0_wdata = d;
    end else begin
      bus0.p1_req = req; bus0.p1_we = we; bus0.p1_addr = a; bus0.p1_wdata = d;
    end
  endtask

  // Model: memory array and last read value; expected response queued at issue time
  task automatic issue(input bit port, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit chk_w);
    exp_t e;
    if (we) begin
      ref_mem[a] = d;
      e.chk = chk_w;
      e.rd  = model_rdata;
    end else begin
      e.chk = 1'b1;
      e.rd  = ref_mem[a];
      model_rdata = ref_mem[a];
    end
    if (port) exp1.push_back(e);
    else      exp0.push_back(e);
    drive(port, 1'b1, we, a, d);
  endtask

  task automatic wait_ack(input bit port, input int exp_lat);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = port ? bus0.p1_ack : bus0.p0_ack;
    end
    if (!got) check(port ? "p1_ack_timeout" : "p0_ack_timeout", 32'(got), 1);
    else if (exp_lat != 0) check(port ? "p1_latency" : "p0_latency", 32'(n), 32'(exp_lat));
    @(posedge clk);
    #1;
    if (port) bus0.p1_req = 1'b0;
    else      bus0.p0_req = 1'b0;
  endtask

  task automatic txn(input bit port, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit chk_w, input int lat);
    issue(port, we, a, d, chk_w);
    wait_ack(port, lat);
  endtask

  task automatic main_seq();
    int w0;
    int n;
    bit first;
    for (int i = 0; i < 512; i++) begin
      mem0[i]    = '0;
      ref_mem[i] = '0;
    end
    bus0.mem_dout = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    model_last  = 1'b1;
    model_rdata = '0;

    // Reset with a port-0 read already pending
    rst = 1'b1;
    issue(1'b0, 1'b0, 9'h000, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p0_ack",   32'(bus0.p0_ack), 0);
    check("rst_p1_ack",   32'(bus0.p1_ack), 0);
    check("rst_mem_we",   32'(bus0.mem_we), 0);
    check("rst_mem_re",   32'(bus0.mem_re), 0);
    check("rst_busy",     32'(bus0.busy), 0);
    check("rst_rdata",    32'(bus0.rdata), 0);
    check("rst_mem_addr", 32'(bus0.mem_addr), 0);
    check("rst_mem_din",  32'(bus0.mem_din), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ack(1'b0, 3);

    // Port 0 write, read back, then a write that must leave rdata alone
    w0 = we_cnt;
    txn(1'b0, 1'b1, 9'h100, 12'o0400, 1'b1, 3);
    check("mem_we_cycles", 32'(we_cnt - w0), 1);
    txn(1'b0, 1'b0, 9'h100, '0, 1'b1, 3);
    txn(1'b0, 1'b1, 9'h0AA, 12'o1234, 1'b1, 3);

    // Loader write while CPU request rises mid-ACCESS
    own0.push_back(1'b1);
    own0.push_back(1'b0);
    fork
      txn(1'b1, 1'b1, 9'h1FF, 12'hFFF, 1'b0, 3);
      begin
        @(posedge clk);
        #1;
        txn(1'b0, 1'b0, 9'h1FF, '0, 1'b0, 0);
      end
    join

    // Reset during DONE of a loader read
    issue(1'b1, 1'b0, 9'h1FF, '0, 1'b0);
    n = 0;
    while (bus0.p1_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("p1_read_before_rst", 32'(bus0.p1_ack), 1);
    #1 rst = 1'b1;
    bus0.p1_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_p1_ack", 32'(bus0.p1_ack), 0);
    check("midrst_busy",   32'(bus0.busy), 0);
    check("midrst_rdata",  32'(bus0.rdata), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_last  = 1'b1;
    model_rdata = '0;
    txn(1'b1, 1'b0, 9'h1FF, '0, 1'b0, 3);

    // Both ports held through four transactions: strict alternation
    first = model_last ? 1'b0 : 1'b1;
    own0.push_back(first);
    own0.push_back(~first);
    own0.push_back(first);
    own0.push_back(~first);
    fork
      begin
        txn(1'b0, 1'b1, 9'h010, 12'($urandom), 1'b0, 0);
        txn(1'b0, 1'b1, 9'h011, 12'($urandom), 1'b0, 0);
      end
      begin
        txn(1'b1, 1'b1, 9'h110, 12'($urandom), 1'b0, 0);
        txn(1'b1, 1'b1, 9'h111, 12'($urandom), 1'b0, 0);
      end
    join

    // Random traffic, each port confined to its own half of memory
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        txn(1'b0, 1'($urandom_range(0, 1)), {1'b0, 8'($urandom)}, 12'($urandom), 1'b0, 0);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        txn(1'b1, 1'($urandom_range(0, 1)), {1'b1, 8'($urandom)}, 12'($urandom), 1'b0, 0);
      end
    join

    repeat (4) @(posedge clk);
    check("exp0_drained", 32'(exp0.size()), 0);
    check("exp1_drained", 32'(exp1.size()), 0);
    check("own0_drained", 32'(own0.size()), 0);
  endtask

  task automatic prio_seq();
    int n;
    bus1.mem_dout = '0;
    bus1.p0_req = 1'b0; bus1.p0_we = 1'b1; bus1.p0_addr = 9'h001; bus1.p0_wdata = 12'h123;
    bus1.p1_req = 1'b0; bus1.p1_we = 1'b1; bus1.p1_addr = 9'h101; bus1.p1_wdata = 12'h456;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    repeat (6) own1.push_back(1'b0);
    own1.push_back(1'b1);
    bus1.p0_req = 1'b1;
    bus1.p1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (bus1.p0_ack !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("prio_p0_ack_seen", 32'(bus1.p0_ack), 1);
      @(posedge clk);
      #1;
      if (i == 5) bus1.p0_req = 1'b0;
      else        bus1.p0_addr = 9'(i + 2);
    end
    n = 0;
    while (bus1.p1_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("prio_p1_ack_seen", 32'(bus1.p1_ack), 1);
    @(posedge clk);
    #1 bus1.p1_req = 1'b0;
    repeat (3) @(posedge clk);
    check("own1_drained", 32'(own1.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      main_seq();
      prio_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
